distance_eval_scheduler: RTL and testbench
==========================================

// Module: distance_eval_scheduler
// PURPOSE
// - Shares one route-distance evaluator (start/done, route in, 12-bit distance out) among N_REQ GA requesters.
// - Round-robin grant; launches the evaluator, holds the route stable, and returns the distance to the winner with an ack pulse.
// - Sits between the population/fitness stage and the single evaluator + distance-table ROM pair.
// PARAMETERS
// - N_REQ        4    number of requesters (2..8)
// - ROUTE_W      150  route bus width per requester (30 cities x 5 bits)
// - DIST_W       12   distance result width
// - TIMEOUT_CYC  64   cycles in WAIT before the evaluator is declared hung
// PORTS
// - clk         in   1               single clock; all logic on posedge
// - rst         in   1               synchronous, active-high reset
// - req         in   N_REQ           per-requester request level; held until ack
// - route_flat  in   N_REQ*ROUTE_W   requester i route at [i*ROUTE_W +: ROUTE_W]
// - ack         out  N_REQ           one-hot, one-cycle pulse: result for that requester valid
// - dist_out    out  DIST_W          distance for acked requester (all ones on timeout)
// - dist_err    out  1               high with ack when result is a timeout
// - busy        out  1               high in LAUNCH/WAIT/RESP
// - eval_start  out  1               one-cycle start pulse to evaluator
// - eval_route  out  ROUTE_W         registered route of granted requester
// - eval_done   in   1               evaluator one-cycle done strobe
// - eval_dist   in   DIST_W          evaluator result, valid while eval_done=1
// BEHAVIOUR
// - Reset: ack=0, dist_out=0, dist_err=0, busy=0, eval_start=0, eval_route=0, state=IDLE, rr_ptr=N_REQ-1 (req 0 wins first).
// - States: IDLE -> LAUNCH -> WAIT -> RESP -> IDLE.
// - IDLE: any req -> pick first set bit searching rr_ptr+1, rr_ptr+2, ... (mod N_REQ); latch grant idx, register route into eval_route; rr_ptr<=idx; go LAUNCH.
// - LAUNCH: eval_start=1 for exactly this cycle; clear timeout counter; go WAIT.
// - WAIT: eval_done=1 -> capture eval_dist, dist_err=0, go RESP. Counter reaches TIMEOUT_CYC-1 without done -> dist_out all ones, dist_err=1, go RESP.
// - RESP: ack[idx]=1 for one cycle with dist_out/dist_err; go IDLE. Earliest next grant is the IDLE cycle after RESP.
// - Latency: grant cycle to ack = evaluator latency + 3 cycles; no back-to-back overlap (one outstanding eval).
// - eval_route stays constant from LAUNCH through RESP; route_flat changes after grant are ignored.
// - req dropped mid-operation: evaluation completes, ack still pulsed to that index.
// - eval_done outside WAIT: ignored. eval_done on the timeout cycle: done wins (valid result, dist_err=0).
// - dist_out/dist_err hold last value between acks.
// - rst mid-operation: immediate return to reset values; evaluator is not re-started, so next LAUNCH after reset relies on evaluator idling.
// CONFIGURATION
// - Macro BEST_TRACK_EN: adds outputs best_dist[DIST_W-1:0], best_idx[$clog2(N_REQ)-1:0], best_valid, input best_clr.
//   On each non-error RESP: if !best_valid or dist < best_dist, update all three (ties keep earlier).
//   best_clr (sync) or rst: best_valid=0, best_dist=all ones, best_idx=0; best_clr same cycle as RESP: clear wins.
// - Without macro: ports and logic absent; core behaviour identical.
// STRUCTURE
// - Package gbr_sched_pkg: state enum (IDLE, LAUNCH, WAIT, RESP), DIST_W/ROUTE_W default constants, DIST_TIMEOUT = all ones.
// - Sub-module rr_arbiter: parameterised N_REQ round-robin pick (req, rr_ptr -> grant_idx, grant_vld); combinational.
// - Top: FSM, route register, timeout counter, response regs, optional best tracker.
// TESTING (N_REQ=4, stub evaluator with 30-cycle latency)
// - After rst, req=4'b1111 -> acks in order 0,1,2,3,0; each ack exactly 33 cycles after its grant.
// - req=4'b0100 only, stub returns 12'd517 -> ack=4'b0100, dist_out=517, dist_err=0, one eval_start pulse.
// - Stub never asserts done -> ack after TIMEOUT_CYC cycles in WAIT, dist_out=12'hFFF, dist_err=1; next req served normally.
// - Change route_flat of granted requester during WAIT -> eval_route unchanged; req drop mid-WAIT -> ack still pulses.
// - rst asserted in WAIT -> next cycle all outputs at reset values, busy=0, no ack; req 0 wins next.
// - BEST_TRACK_EN: results 700,450,450,900 for req 0..3 -> best_dist=450, best_idx=1; best_clr -> best_valid=0.

Source files
------------

// File: rtl/distance_eval_scheduler_pkg.sv
// Shared types and constants for the distance evaluator scheduler.
// Optional best-result tracking is enabled by defining BEST_TRACK_EN.
package gbr_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } sched_state_e;

  localparam int DIST_W_DEF  = 12;
  localparam int ROUTE_W_DEF = 150;

  // Distance reported when the evaluator never answers.
  localparam logic [DIST_W_DEF-1:0] DIST_TIMEOUT = '1;

endpackage

// File: rtl/distance_eval_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [IDX_W-1:0] cand;

  // Walk from the farthest slot back to the nearest so the nearest set bit wins.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      if (req[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/distance_eval_scheduler.sv
// Shares one route-distance evaluator among N_REQ requesters, round-robin.
// Define BEST_TRACK_EN to add the best-distance tracker ports and logic.
//
// Handshake: req is a level held by the requester; the scheduler answers
// with a one-cycle one-hot ack carrying dist_out/dist_err. Towards the
// evaluator, eval_start is a one-cycle pulse and eval_done a one-cycle
// strobe qualifying eval_dist; only one evaluation is ever outstanding.
module distance_eval_scheduler
  import gbr_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ROUTE_W     = ROUTE_W_DEF,
  parameter int DIST_W      = DIST_W_DEF,
  parameter int TIMEOUT_CYC = 64,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ROUTE_W-1:0] route_flat,
  output logic [N_REQ-1:0]         ack,
  output logic [DIST_W-1:0]        dist_out,
  output logic                     dist_err,
  output logic                     busy,
  output logic                     eval_start,
  output logic [ROUTE_W-1:0]       eval_route,
  input  logic                     eval_done,
  input  logic [DIST_W-1:0]        eval_dist,
  output sched_state_e             state_dbg
`ifdef BEST_TRACK_EN
  ,
  input  logic                     best_clr,
  output logic [DIST_W-1:0]        best_dist,
  output logic [IDX_W-1:0]         best_idx,
  output logic                     best_valid
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ROUTE_W-1:0] route_q, route_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic             err_q, err_d;

  logic [IDX_W-1:0]   grant_idx;
  logic               grant_vld;
  logic [ROUTE_W-1:0] route_sel;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr_q),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    route_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) route_sel = route_flat[i*ROUTE_W +: ROUTE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      route_q  <= '0;
      cnt_q    <= '0;
      dist_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      route_q  <= route_d;
      cnt_q    <= cnt_d;
      dist_q   <= dist_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    route_d  = route_q;
    cnt_d    = cnt_q;
    dist_d   = dist_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          idx_d    = grant_idx;
          rr_ptr_d = grant_idx;
          route_d  = route_sel;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A done on the final timeout cycle still delivers a valid result.
        if (eval_done) begin
          dist_d  = eval_dist;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          dist_d  = '1;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack        = '0;
    busy       = (state_q != IDLE);
    eval_start = (state_q == LAUNCH);
    if (state_q == RESP) ack = N_REQ'(1) << idx_q;
  end

  assign eval_route = route_q;
  assign dist_out   = dist_q;
  assign dist_err   = err_q;
  assign state_dbg  = state_q;

`ifdef BEST_TRACK_EN
  logic [DIST_W-1:0] best_dist_q, best_dist_d;
  logic [IDX_W-1:0]  best_idx_q, best_idx_d;
  logic              best_valid_q, best_valid_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      best_dist_q  <= '1;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_dist_q  <= best_dist_d;
      best_idx_q   <= best_idx_d;
      best_valid_q <= best_valid_d;
    end
  end

  // Strict less-than keeps the earlier requester on a tie.
  always_comb begin
    best_dist_d  = best_dist_q;
    best_idx_d   = best_idx_q;
    best_valid_d = best_valid_q;
    if (best_clr) begin
      best_dist_d  = '1;
      best_idx_d   = '0;
      best_valid_d = 1'b0;
    end else if (state_q == RESP && !err_q &&
                 (!best_valid_q || dist_q < best_dist_q)) begin
      best_dist_d  = dist_q;
      best_idx_d   = idx_q;
      best_valid_d = 1'b1;
    end
  end

  assign best_dist  = best_dist_q;
  assign best_idx   = best_idx_q;
  assign best_valid = best_valid_q;
`endif

endmodule

// File: tb/tb_distance_eval_scheduler.sv
// Directed bench for distance_eval_scheduler with a stub evaluator and a
// transaction-timing reference model checked every cycle.
module tb_distance_eval_scheduler;

  localparam int NR    = 4;
  localparam int RW    = 150;
  localparam int DW    = 12;
  localparam int TOUT  = 64;
  localparam int IW    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*RW-1:0] route_flat = '0;
  logic [NR-1:0]    ack;
  logic [DW-1:0]    dist_out;
  logic             dist_err;
  logic             busy;
  logic             eval_start;
  logic [RW-1:0]    eval_route;
  logic             eval_done = 1'b0;
  logic [DW-1:0]    eval_dist = '0;
  logic [1:0]       state_dbg;
`ifdef BEST_TRACK_EN
  logic             best_clr = 1'b0;
  logic [DW-1:0]    best_dist;
  logic [IW-1:0]    best_idx;
  logic             best_valid;
`endif

  distance_eval_scheduler #(
    .N_REQ(NR), .ROUTE_W(RW), .DIST_W(DW), .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .route_flat (route_flat),
    .ack        (ack),
    .dist_out   (dist_out),
    .dist_err   (dist_err),
    .busy       (busy),
    .eval_start (eval_start),
    .eval_route (eval_route),
    .eval_done  (eval_done),
    .eval_dist  (eval_dist),
    .state_dbg  (state_dbg)
`ifdef BEST_TRACK_EN
    ,
    .best_clr   (best_clr),
    .best_dist  (best_dist),
    .best_idx   (best_idx),
    .best_valid (best_valid)
`endif
  );

  // ---------------- clock / reset / counters ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stub evaluator ----------------
  // Answers 30 cycles after it registers the start pulse; the distance it
  // returns is the low DW bits of the route it was handed.
  int stub_left = 0;
  bit stub_hang = 1'b0;

  always @(negedge clk) if (eval_start === 1'b1) stub_left = 31;

  always @(posedge clk) begin
    #1;
    eval_done = 1'b0;
    eval_dist = DW'($urandom);
    if (stub_left > 0) begin
      stub_left--;
      if (stub_left == 0 && !stub_hang) begin
        eval_done = 1'b1;
        eval_dist = eval_route[DW-1:0];
      end
    end
  end

  // ---------------- reference model + compare ----------------
  bit            check_en = 1'b0;
  bit            m_active = 1'b0;
  int            m_g = 0, m_r = -1, m_idx = 0, m_rr = NR - 1;
  logic [RW-1:0] m_route = '0;
  logic [DW-1:0] m_dist = '0;
  logic          m_err = 1'b0;

  int acks_idx[$];
  int acks_cyc[$];
  int starts_cyc[$];

  function automatic int rr_pick(input int ptr, input logic [NR-1:0] r);
    for (int k = 1; k <= NR; k++) begin
      if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NR-1:0] e_ack;
    int pick;
    if (check_en) begin
      e_ack = (m_active && cyc == m_r) ? NR'(1) << m_idx : '0;
      check("ack",        ack,        e_ack);
      check("busy",       busy,       m_active && cyc > m_g);
      check("eval_start", eval_start, m_active && cyc == m_g + 1);
      check("dist_out",   dist_out,   m_dist);
      check("dist_err",   dist_err,   m_err);
      check("eval_route", eval_route, m_route);
    end
    for (int i = 0; i < NR; i++) begin
      if (ack[i] === 1'b1) begin
        acks_idx.push_back(i);
        acks_cyc.push_back(cyc);
      end
    end
    if (eval_start === 1'b1) starts_cyc.push_back(cyc);

    if (rst) begin
      m_active = 1'b0; m_r = -1; m_rr = NR - 1;
      m_route = '0; m_dist = '0; m_err = 1'b0;
      check_en = 1'b1;
    end else if (m_active) begin
      if (m_r >= 0 && cyc == m_r) begin
        m_active = 1'b0;
      end else if (m_r < 0 && cyc >= m_g + 2) begin
        if (eval_done) begin
          m_r = cyc + 1; m_dist = eval_dist; m_err = 1'b0;
        end else if (cyc - (m_g + 2) == TOUT - 1) begin
          m_r = cyc + 1; m_dist = '1; m_err = 1'b1;
        end
      end
    end else begin
      pick = rr_pick(m_rr, req);
      if (pick >= 0) begin
        m_active = 1'b1; m_g = cyc; m_r = -1; m_idx = pick; m_rr = pick;
        for (int i = 0; i < NR; i++) if (i == pick) m_route = route_flat[i*RW +: RW];
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_route(input int i, input logic [DW-1:0] low);
    logic [RW-1:0] r;
    for (int b = 0; b < RW; b++) r[b] = 1'($urandom_range(0, 1));
    r[DW-1:0] = low;
    route_flat[i*RW +: RW] = r;
  endtask

  task automatic clear_logs();
    acks_idx.delete();
    acks_cyc.delete();
    starts_cyc.delete();
  endtask

  task automatic wait_acks(input int n, input int budget, input string name);
    int k = 0;
    while (acks_idx.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    n_tests++;
    if (acks_idx.size() < n) begin
      n_fail++;
      $display("FAIL %s: saw %0d acks, required %0d within %0d cycles", name, acks_idx.size(), n, budget);
    end
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k = 0;
    while (starts_cyc.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    n_tests++;
    if (starts_cyc.size() < n) begin
      n_fail++;
      $display("FAIL %s: saw %0d starts, required %0d", name, starts_cyc.size(), n);
    end
  endtask

  // ---------------- directed scenarios ----------------
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    for (int i = 0; i < NR; i++) set_route(i, DW'(100 + i * 11));
    repeat (3) tick();
    rst = 1'b0;
    check("rst_ack",   ack,        '0);
    check("rst_busy",  busy,       1'b0);
    check("rst_dist",  dist_out,   '0);
    check("rst_err",   dist_err,   1'b0);
    check("rst_route", eval_route, '0);
    check("rst_state", state_dbg,  2'd0);

    // All four requesting: round-robin order 0,1,2,3,0 at 33 cycles each.
    clear_logs();
    req = 4'b1111;
    wait_acks(5, 220, "rr_acks");
    tick();
    req = '0;
    for (int k = 0; k < 5 && k < acks_idx.size() && k < starts_cyc.size(); k++) begin
      check($sformatf("rr_order%0d", k), acks_idx[k], exp_order[k]);
      check($sformatf("rr_latency%0d", k), acks_cyc[k] - (starts_cyc[k] - 1), 33);
    end

    // Single requester 2 with distance 517.
    repeat (3) tick();
    set_route(2, 12'd517);
    clear_logs();
    req = 4'b0100;
    wait_acks(1, 60, "single_ack");
    check("single_ack_vec", ack, 4'b0100);
    check("single_dist", dist_out, 12'd517);
    check("single_err", dist_err, 1'b0);
    check("single_starts", starts_cyc.size(), 1);
    tick();
    req = '0;

    // Hung evaluator: timeout after 64 WAIT cycles.
    repeat (3) tick();
    stub_hang = 1'b1;
    clear_logs();
    req = 4'b0001;
    wait_acks(1, 120, "tout_ack");
    check("tout_ack_vec", ack, 4'b0001);
    check("tout_dist", dist_out, 12'hFFF);
    check("tout_err", dist_err, 1'b1);
    if (acks_cyc.size() > 0 && starts_cyc.size() > 0)
      check("tout_latency", acks_cyc[0] - starts_cyc[0], 65);
    tick();
    req = '0;
    stub_hang = 1'b0;

    // Normal service right after a timeout.
    repeat (2) tick();
    set_route(3, 12'd1234);
    clear_logs();
    req = 4'b1000;
    wait_acks(1, 60, "post_tout_ack");
    check("post_tout_ack_vec", ack, 4'b1000);
    check("post_tout_dist", dist_out, 12'd1234);
    check("post_tout_err", dist_err, 1'b0);
    tick();
    req = '0;

    // Route change and request drop while waiting.
    repeat (2) tick();
    set_route(1, 12'd321);
    clear_logs();
    req = 4'b0010;
    wait_starts(1, 10, "chg_start");
    repeat (5) tick();
    set_route(1, 12'd999);
    req = '0;
    wait_acks(1, 60, "chg_ack");
    check("chg_ack_vec", ack, 4'b0010);
    check("chg_dist", dist_out, 12'd321);
    check("chg_route_low", eval_route[DW-1:0], 12'd321);
    tick();

    // Reset in the middle of WAIT.
    set_route(2, 12'd77);
    clear_logs();
    req = 4'b0100;
    wait_starts(1, 10, "rstw_start");
    repeat (10) tick();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
    check("rstw_busy",  busy,       1'b0);
    check("rstw_ack",   ack,        '0);
    check("rstw_dist",  dist_out,   '0);
    check("rstw_err",   dist_err,   1'b0);
    check("rstw_route", eval_route, '0);
    set_route(0, 12'd55);
    clear_logs();
    req = 4'b1111;
    wait_acks(1, 60, "rstw_next_ack");
    if (acks_idx.size() > 0) check("rstw_first_idx", acks_idx[0], 0);
    check("rstw_next_dist", dist_out, 12'd55);
    tick();
    req = '0;

`ifdef BEST_TRACK_EN
    repeat (2) tick();
    best_clr = 1'b1;
    tick();
    best_clr = 1'b0;
    check("best_clr_valid", best_valid, 1'b0);
    check("best_clr_dist", best_dist, 12'hFFF);
    set_route(0, 12'd700);
    set_route(1, 12'd450);
    set_route(2, 12'd450);
    set_route(3, 12'd900);
    clear_logs();
    req = 4'b1111;
    wait_acks(4, 180, "best_acks");
    tick();
    req = '0;
    tick();
    check("best_dist", best_dist, 12'd450);
    check("best_idx", best_idx, 2'd1);
    check("best_valid", best_valid, 1'b1);
    best_clr = 1'b1;
    tick();
    best_clr = 1'b0;
    check("best_clr2_valid", best_valid, 1'b0);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
